alu_mul_seq: RTL and testbench

Multi-cycle shift-add multiply sequencer that borrows the shared 32-bit ALU to execute RV32M `MUL`, returning the low 32 bits of the product. It sits beside the execute stage. While busy it requests the ALU and drives its operand and control inputs; the top-level mux grants the ALU on `alu_req`. The sequencer owns a small FSM, operand shift registers and a result register, and skips trailing zero multiplier bits to terminate early.

---
 rtl/alu_mul_seq.sv | 103 ++++++++++
 tb/tb_alu_mul_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-add multiplier that borrows the shared ALU for its additions.
// Returns the low WIDTH bits of op_a*op_b and stops once no multiplier bits remain.
module alu_mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             alu_req,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_out
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] mplier_next;

   // The ALU adds acc + mcand; only taken when the current multiplier bit is set.
   always_comb begin
      acc_next    = mplier[0] ? alu_out : acc;
      mplier_next = mplier >> 1;
   end

   // Operands come only from registers so the ALU path never sees a raw input.
   assign alu_a    = (state == RUN) ? acc   : '0;
   assign alu_b    = (state == RUN) ? mcand : '0;
   assign alu_ctrl = 4'b0000;

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values of the others, matching the hardware.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         alu_req <= 1'b0;
         result  <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
      end else if (flush) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         alu_req <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mcand   <= op_a;
                  mplier  <= op_b;
                  acc     <= '0;
                  state   <= RUN;
                  busy    <= 1'b1;
                  alu_req <= 1'b1;
               end
            end
            RUN: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier_next;
               // Early exit: trailing zero multiplier bits contribute nothing.
               if (mplier_next == '0) begin
                  result  <= acc_next;
                  state   <= DONE;
                  alu_req <= 1'b0;
                  done    <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
               alu_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: vector table of multiplies plus hand-written
// flush, start-while-busy and reset sequences; the shared ALU is modelled here.
module tb_alu_mul_seq;

   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [31:0] op_a, op_b;
   logic        busy, done, alu_req;
   logic [31:0] result, alu_a, alu_b, alu_out;
   logic [3:0]  alu_ctrl;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Shared ALU: only the add operation is exercised by the sequencer.
   assign alu_out = (alu_ctrl == 4'b0000) ? alu_a + alu_b : 32'hDEAD_BEEF;

   alu_mul_seq #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .flush(flush),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
      .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_out(alu_out)
   );

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      int          n;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issues one multiply and follows it to done; all sampling on falling edges.
   task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int exp_n);
      int runs;
      bit fin;
      @(negedge clk);
      op_a = a; op_b = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, "_first_alu_a"}, alu_a, 32'd0);
      check({name, "_first_alu_b"}, alu_b, a);
      runs = 0;
      fin  = 1'b0;
      for (int i = 0; i < 40 && !fin; i++) begin
         if (alu_req) runs++;
         if (done) fin = 1'b1;
         else @(negedge clk);
      end
      check({name, "_done_seen"}, {31'd0, fin}, 32'd1);
      check({name, "_run_cycles"}, runs, exp_n);
      check({name, "_result"}, result, exp_r);
      check({name, "_busy_in_done"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
      check({name, "_done_after"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int dcount;
      vecs[0] = '{"basic_3x5",   32'd3,          32'd5,          32'd15,         3};
      vecs[1] = '{"zero_mplier", 32'h0000_1234,  32'd0,          32'd0,          1};
      vecs[2] = '{"max_wrap",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32};
      vecs[3] = '{"neg3_x7",     32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFEB,  3};
      vecs[4] = '{"two_x2",      32'd2,          32'd2,          32'd4,          2};
      vecs[5] = '{"six_x7",      32'd6,          32'd7,          32'd42,         3};

      reset = 1'b1; start = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_alu_req", {31'd0, alu_req}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_b", alu_b, 32'd0);
      check("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 6; i++)
         run_mul(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].n);

      // Flush in the 5th RUN cycle of a 32-cycle multiply; result keeps 42.
      @(negedge clk);
      op_a = 32'd100; op_b = 32'h8000_0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("flush_in_run", {31'd0, alu_req}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_alu_req", {31'd0, alu_req}, 32'd0);
      check("flush_done", {31'd0, done}, 32'd0);
      check("flush_result", result, 32'd42);
      dcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) dcount++;
      end
      check("flush_no_activity", dcount, 0);
      check("flush_result_held", result, 32'd42);
      run_mul("after_flush_2x2", 32'd2, 32'd2, 32'd4, 2);

      // start pulsed during RUN and during DONE must be ignored.
      @(negedge clk);
      op_a = 32'd5; op_b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dcount = 0;
      @(negedge clk);
      op_a = 32'd7; op_b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("busy_start_done", {31'd0, done}, 32'd1);
      check("busy_start_result", result, 32'd45);
      if (done) dcount++;
      op_a = 32'd11; op_b = 32'd13; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_start_idle", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         if (done || busy) dcount++;
         @(negedge clk);
      end
      check("busy_start_one_done", dcount, 1);
      check("busy_start_result_held", result, 32'd45);

      // Reset in the 2nd RUN cycle of 9x9, with a same-cycle start.
      @(negedge clk);
      op_a = 32'd9; op_b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1; start = 1'b1; op_a = 32'd3; op_b = 32'd3;
      @(negedge clk);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_alu_req", {31'd0, alu_req}, 32'd0);
      check("midrst_result", result, 32'd0);
      check("midrst_alu_a", alu_a, 32'd0);
      check("midrst_alu_b", alu_b, 32'd0);
      @(negedge clk);
      check("rst_with_start", {31'd0, busy}, 32'd0);
      reset = 1'b0; start = 1'b0;
      dcount = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done || busy) dcount++;
      end
      check("midrst_quiet", dcount, 0);
      check("midrst_result_held", result, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
